redundant_resolve: RTL



---
 rtl/redundant_resolve_pkg.sv | 33 +++
 rtl/redundant_resolve_if.sv | 24 ++
 rtl/redundant_resolve_limb_carry_add.sv | 24 ++
 rtl/redundant_resolve.sv | 86 ++++++++
 4 files changed

// File: rtl/redundant_resolve_pkg.sv
// Shared parameters and types for the BN254 redundant-arithmetic datapath.
// Carries the operand, result and carry-resolution FSM types.
package PARAMS_BN254_d0;

    localparam int ADD_DIV       = 4;
    localparam int LEN_12M_TILDE = 272;
    localparam int L3_CARRY      = 8;
    localparam int QPMM_FP_W     = 289;
    localparam int RES_CARRY_W   = L3_CARRY + 1;

    typedef logic [LEN_12M_TILDE/ADD_DIV-1:0] fp_div4_t;
    typedef logic [QPMM_FP_W-1:0]             qpmm_fp_t;

    typedef struct packed {
        logic [L3_CARRY-1:0] carry;
        fp_div4_t            val;
    } redundant_limb_L3_t;

    // Limb i occupies bits [76*i +: 76] as {carry_i, val_i}.
    typedef redundant_limb_L3_t [ADD_DIV-1:0] redundant_poly_L3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } resolve_state_t;

    typedef struct packed {
        resolve_state_t state;
        logic [1:0]     idx;
    } resolve_dbg_t;

endpackage

// File: rtl/redundant_resolve_if.sv
// Operand-in / result-out handshake bundle for the carry-resolution stage.
// Both channels: a transfer happens on a rising clk edge where valid and ready are both high;
// a source holds valid and data stable until that edge, and ready never waits on valid.
interface redundant_resolve_if;
    import PARAMS_BN254_d0::*;

    logic             in_valid;
    logic             in_ready;
    redundant_poly_L3 in_data;
    logic             out_valid;
    logic             out_ready;
    qpmm_fp_t         out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/redundant_resolve_limb_carry_add.sv
// One limb step of carry resolution: value plus running carry, then fold in the
// limb's own carry field to form the carry into the next limb.
module limb_carry_add #(
    parameter int W   = 68,
    parameter int CW  = 8,
    parameter int RCW = 9
) (
    input  logic [W-1:0]   val,
    input  logic [RCW-1:0] cin,
    input  logic [CW-1:0]  carry,
    output logic [W-1:0]   sum,
    output logic [RCW-1:0] cout
);

    logic [W:0] acc;

    // cout peaks at 1 + 255 = 256, which fits RCW bits without wrap.
    always_comb begin
        acc  = {1'b0, val} + (W+1)'(cin);
        sum  = acc[W-1:0];
        cout = RCW'(acc[W]) + RCW'(carry);
    end

endmodule

// File: rtl/redundant_resolve.sv
// Sequential carry resolution of a level-3 redundant operand into a canonical
// integer, one limb per cycle; no modular reduction is applied.
module redundant_resolve
    import PARAMS_BN254_d0::*;
#(
    parameter int LIMBS = ADD_DIV,
    parameter int W     = LEN_12M_TILDE/ADD_DIV,
    parameter int CW    = L3_CARRY
) (
    input  logic                clk,
    input  logic                rstn,
    redundant_resolve_if.slave  bus,
    output resolve_dbg_t        dbg
);

    localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    resolve_state_t         state;
    redundant_poly_L3       op;
    logic [W*LIMBS-1:0]     res;
    logic [RES_CARRY_W-1:0] cr;
    logic [IW-1:0]          idx;

    logic [W-1:0]           limb_val;
    logic [CW-1:0]          limb_carry;
    logic [W-1:0]           limb_sum;
    logic [RES_CARRY_W-1:0] cr_next;

    always_comb begin
        limb_val   = W'(op[idx].val);
        limb_carry = CW'(op[idx].carry);
    end

    limb_carry_add #(
        .W   (W),
        .CW  (CW),
        .RCW (RES_CARRY_W)
    ) u_limb_add (
        .val   (limb_val),
        .cin   (cr),
        .carry (limb_carry),
        .sum   (limb_sum),
        .cout  (cr_next)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            op    <= '0;
            res   <= '0;
            cr    <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op    <= bus.in_data;
                        cr    <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res[idx*W +: W] <= limb_sum;
                    cr              <= cr_next;
                    idx             <= idx + 1'b1;
                    if (idx == IW'(LIMBS-1)) state <= DONE;
                end
                DONE: begin
                    // Retire only; the earliest new accept is the following cycle.
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    // Final carry sits directly above the limbs; the remaining top bits stay zero.
    assign bus.out_data  = qpmm_fp_t'({cr, res});

    assign dbg.state = state;
    assign dbg.idx   = 2'(idx);

endmodule
